tblink_rpc_invoke_queue: RTL and testbench

- RTL stage directly downstream of the TbLink HVL invoke dispatcher.
- Accepts method-invoke requests (method id, call id, packed params, blocking flag) from the DPI/HVL side.
- Buffers requests, issues them one at a time to a pin-level BFM, and returns one response per call, tagged with the call id and a status code.
- Blocking calls wait for a BFM response, bounded by a timeout. Non-blocking calls are acknowledged as soon as the BFM accepts them.

---
 rtl/tblink_rpc_invoke_queue_pkg.sv | 27 ++
 rtl/tblink_rpc_invoke_queue_if.sv | 50 +++++
 rtl/tblink_rpc_invoke_queue_sync_fifo.sv | 67 ++++++
 rtl/tblink_rpc_invoke_queue.sv | 201 ++++++++++++++++++++
 tb/tb_tblink_rpc_invoke_queue.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tblink_rpc_invoke_queue_pkg.sv
// Shared types and helpers for the TbLink RPC invoke queue.
//   invoke_state_e : invoke FSM states
//   rsp_status_e   : status code returned with every response
//   STATUS_W       : width of the status field
//   timer_w()      : timeout counter width for a given limit
package tblink_rpc_rtl_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RETURN   = 2'd3
    } invoke_state_e;

    typedef enum logic [STATUS_W-1:0] {
        RSP_OK      = 2'd0,
        RSP_TIMEOUT = 2'd1
    } rsp_status_e;

    // Counter width able to hold 0..timeout, never narrower than 1 bit.
    function automatic int timer_w(input int timeout);
        return (timeout <= 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tblink_rpc_invoke_queue_if.sv
// Handshake bundle of the invoke queue.
//   req_* : method-invoke requests from the HVL dispatcher
//   bfm_* : one-at-a-time issue to the pin-level BFM and its response pulse
//   rsp_* : per-call response back to the HVL side
// slave  = view of the invoke queue, master = view of the surrounding logic.
interface tblink_rpc_invoke_queue_if #(
    parameter int METHOD_ID_W = 8,
    parameter int CALL_ID_W   = 8,
    parameter int PARAM_W     = 64,
    parameter int RET_W       = 64
);
    logic                                   req_valid;
    logic                                   req_ready;
    logic [METHOD_ID_W-1:0]                 req_method;
    logic [CALL_ID_W-1:0]                   req_call_id;
    logic [PARAM_W-1:0]                     req_params;
    logic                                   req_blocking;

    logic                                   bfm_valid;
    logic                                   bfm_ready;
    logic [METHOD_ID_W-1:0]                 bfm_method;
    logic [PARAM_W-1:0]                     bfm_params;
    logic                                   bfm_rsp_valid;
    logic [RET_W-1:0]                       bfm_rsp_retval;

    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [CALL_ID_W-1:0]                   rsp_call_id;
    logic [RET_W-1:0]                       rsp_retval;
    logic [tblink_rpc_rtl_pkg::STATUS_W-1:0] rsp_status;

    modport slave (
        input  req_valid, req_method, req_call_id, req_params, req_blocking,
        output req_ready,
        output bfm_valid, bfm_method, bfm_params,
        input  bfm_ready, bfm_rsp_valid, bfm_rsp_retval,
        output rsp_valid, rsp_call_id, rsp_retval, rsp_status,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_method, req_call_id, req_params, req_blocking,
        input  req_ready,
        input  bfm_valid, bfm_method, bfm_params,
        output bfm_ready, bfm_rsp_valid, bfm_rsp_retval,
        input  rsp_valid, rsp_call_id, rsp_retval, rsp_status,
        output rsp_ready
    );

endinterface

// File: rtl/tblink_rpc_invoke_queue_sync_fifo.sv
// Synchronous request FIFO (module tblink_rpc_sync_fifo).
//   clock, reset_n : clock and asynchronous active-low reset
//   push, wdata    : write strobe and data (ignored when full)
//   pop, rdata     : read strobe (ignored when empty) and head-of-queue data
//   full, empty    : occupancy flags
//   count          : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module tblink_rpc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;

    // Storage array; contents are only observed when the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; push+pop in the same cycle keeps count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tblink_rpc_invoke_queue.sv
// TbLink RPC invoke queue: buffers method-invoke requests, issues them one at
// a time to a pin-level BFM and returns one tagged response per call.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : request / BFM issue / response handshakes (slave view)
//   count          : request FIFO occupancy
//   busy           : FSM active or requests queued
//   err_stray      : sticky, a BFM response arrived outside WAIT_RSP
// Blocking calls wait for the BFM response (bounded by TIMEOUT cycles, 0 =
// unbounded); non-blocking calls complete on the BFM issue handshake.
module tblink_rpc_invoke_queue #(
    parameter int METHOD_ID_W = 8,
    parameter int CALL_ID_W   = 8,
    parameter int PARAM_W     = 64,
    parameter int RET_W       = 64,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                       clock,
    input  logic                       reset_n,
    tblink_rpc_invoke_queue_if.slave   bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       err_stray
);
    import tblink_rpc_rtl_pkg::*;

    localparam int ENTRY_W = METHOD_ID_W + CALL_ID_W + PARAM_W + 1;
    localparam int TMR_W   = timer_w(TIMEOUT);
    localparam bit TMO_EN  = (TIMEOUT != 0);
    // When TIMEOUT is 0 this value is never compared (TMO_EN is clear).
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    invoke_state_e          state_r;
    invoke_state_e          state_next_s;

    logic [ENTRY_W-1:0]     fifo_rdata_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic                   push_s;
    logic                   pop_s;

    logic [METHOD_ID_W-1:0] hold_method_r;
    logic [CALL_ID_W-1:0]   hold_call_id_r;
    logic [PARAM_W-1:0]     hold_params_r;
    logic                   hold_blocking_r;
    logic [RET_W-1:0]       rsp_retval_r;
    rsp_status_e            rsp_status_r;
    logic [TMR_W-1:0]       timer_r;
    logic                   err_stray_r;

    logic                   bfm_valid_s;
    logic                   rsp_valid_s;
    logic                   timeout_hit_s;

    assign push_s        = bus.req_valid && !fifo_full_s;
    assign timeout_hit_s = TMO_EN && (timer_r == TMR_LAST);

    tblink_rpc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .wdata   ({bus.req_method, bus.req_call_id, bus.req_params, bus.req_blocking}),
        .pop     (pop_s),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a BFM response beats a same-cycle timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.bfm_ready) begin
                    state_next_s = hold_blocking_r ? WAIT_RSP : RETURN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT_RSP: begin
                if (bus.bfm_rsp_valid || timeout_hit_s) begin
                    state_next_s = RETURN;
                end else begin
                    state_next_s = WAIT_RSP;
                end
            end
            RETURN: begin
                if (bus.rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RETURN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        bfm_valid_s = 1'b0;
        rsp_valid_s = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            IDLE:     pop_s       = !fifo_empty_s;
            ISSUE:    bfm_valid_s = 1'b1;
            WAIT_RSP: bfm_valid_s = 1'b0;
            RETURN:   rsp_valid_s = 1'b1;
            default:  pop_s       = 1'b0;
        endcase
    end

    // Holding register: the popped call stays here until its response is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_method_r   <= {METHOD_ID_W{1'b0}};
            hold_call_id_r  <= {CALL_ID_W{1'b0}};
            hold_params_r   <= {PARAM_W{1'b0}};
            hold_blocking_r <= 1'b0;
        end else if (pop_s) begin
            hold_method_r   <= fifo_rdata_s[ENTRY_W-1 -: METHOD_ID_W];
            hold_call_id_r  <= fifo_rdata_s[PARAM_W+1 +: CALL_ID_W];
            hold_params_r   <= fifo_rdata_s[1 +: PARAM_W];
            hold_blocking_r <= fifo_rdata_s[0];
        end
    end

    // Response payload and wait timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_retval_r <= {RET_W{1'b0}};
            rsp_status_r <= RSP_OK;
            timer_r      <= {TMR_W{1'b0}};
        end else begin
            case (state_r)
                ISSUE: begin
                    if (bus.bfm_ready) begin
                        timer_r <= {TMR_W{1'b0}};
                        if (!hold_blocking_r) begin
                            rsp_retval_r <= {RET_W{1'b0}};
                            rsp_status_r <= RSP_OK;
                        end
                    end
                end
                WAIT_RSP: begin
                    timer_r <= timer_r + TMR_W'(1);
                    if (bus.bfm_rsp_valid) begin
                        rsp_retval_r <= bus.bfm_rsp_retval;
                        rsp_status_r <= RSP_OK;
                    end else if (timeout_hit_s) begin
                        rsp_retval_r <= {RET_W{1'b0}};
                        rsp_status_r <= RSP_TIMEOUT;
                    end
                end
                default: timer_r <= timer_r;
            endcase
        end
    end

    // Sticky flag for BFM responses nobody is waiting for.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_stray_r <= 1'b0;
        end else if (bus.bfm_rsp_valid && (state_r != WAIT_RSP)) begin
            err_stray_r <= 1'b1;
        end
    end

    assign bus.req_ready   = !fifo_full_s;
    assign bus.bfm_valid   = bfm_valid_s;
    assign bus.bfm_method  = hold_method_r;
    assign bus.bfm_params  = hold_params_r;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.rsp_call_id = hold_call_id_r;
    assign bus.rsp_retval  = rsp_retval_r;
    assign bus.rsp_status  = rsp_status_r;
    assign count           = fifo_count_s;
    assign busy            = (state_r != IDLE) || (fifo_count_s != '0);
    assign err_stray       = err_stray_r;

endmodule

// File: tb/tb_tblink_rpc_invoke_queue.sv
module tb_tblink_rpc_invoke_queue;
    localparam int MW      = 8;
    localparam int CW      = 8;
    localparam int PW      = 64;
    localparam int RW      = 64;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic       err_stray;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [MW-1:0] method;
        logic [PW-1:0] params;
    } issue_t;

    typedef struct {
        logic [CW-1:0] call_id;
        logic [RW-1:0] retval;
        logic [1:0]    status;
    } rsp_t;

    issue_t issue_q[$];
    rsp_t   rsp_q[$];
    issue_t mon_i;
    rsp_t   mon_r;

    tblink_rpc_invoke_queue_if #(
        .METHOD_ID_W (MW),
        .CALL_ID_W   (CW),
        .PARAM_W     (PW),
        .RET_W       (RW)
    ) bus ();

    tblink_rpc_invoke_queue #(
        .METHOD_ID_W (MW),
        .CALL_ID_W   (CW),
        .PARAM_W     (PW),
        .RET_W       (RW),
        .DEPTH       (DEPTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .count     (count),
        .busy      (busy),
        .err_stray (err_stray)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: looks at what will be present at the next rising edge.
    always begin
        @(negedge clock);
        #1;
        if (reset_n) begin
            if (bus.bfm_valid && bus.bfm_ready) begin
                if (issue_q.size() == 0) begin
                    check_val("issue_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_i = issue_q.pop_front();
                    check_val("bfm_method", 64'(bus.bfm_method), 64'(mon_i.method));
                    check_val("bfm_params", bus.bfm_params, mon_i.params);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check_val("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check_val("rsp_call_id", 64'(bus.rsp_call_id), 64'(mon_r.call_id));
                    check_val("rsp_retval", bus.rsp_retval, mon_r.retval);
                    check_val("rsp_status", 64'(bus.rsp_status), 64'(mon_r.status));
                end
            end
        end
    end

    // Drive one request and record its expected issue and response.
    task automatic push(input logic [MW-1:0] m, input logic [CW-1:0] cid, input logic [PW-1:0] p,
                        input logic blk, input logic [RW-1:0] ret, input logic [1:0] st);
        bit acc = 1'b0;
        int waited = 0;
        issue_t ie;
        rsp_t   re;
        bus.req_method   = m;
        bus.req_call_id  = cid;
        bus.req_params   = p;
        bus.req_blocking = blk;
        bus.req_valid    = 1'b1;
        while (!acc && waited < 100) begin
            acc = bus.req_ready;
            @(negedge clock);
            waited++;
        end
        bus.req_valid = 1'b0;
        if (!acc) begin
            check_val("push_timeout", 64'd0, 64'd1);
        end else begin
            ie.method  = m;
            ie.params  = p;
            re.call_id = cid;
            re.retval  = ret;
            re.status  = st;
            issue_q.push_back(ie);
            rsp_q.push_back(re);
        end
    endtask

    // Return at the negedge just before the BFM issue handshake edge.
    task automatic wait_issue();
        int n = 0;
        while (!(bus.bfm_valid && bus.bfm_ready) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check_val("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_rsp(input logic [RW-1:0] ret);
        bus.bfm_rsp_retval = ret;
        bus.bfm_rsp_valid  = 1'b1;
        @(negedge clock);
        bus.bfm_rsp_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rsp_q.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (rsp_q.size() != 0) check_val("drain_timeout", 64'(rsp_q.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.req_valid      = 1'b0;
        bus.req_method     = '0;
        bus.req_call_id    = '0;
        bus.req_params     = '0;
        bus.req_blocking   = 1'b0;
        bus.bfm_ready      = 1'b1;
        bus.bfm_rsp_valid  = 1'b0;
        bus.bfm_rsp_retval = '0;
        bus.rsp_ready      = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("rst_bfm_valid", 64'(bus.bfm_valid), 64'd0);
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_err_stray", 64'(err_stray), 64'd0);
        check_val("rst_bfm_method", 64'(bus.bfm_method), 64'd0);
        check_val("rst_bfm_params", bus.bfm_params, 64'd0);
        check_val("rst_rsp_call_id", 64'(bus.rsp_call_id), 64'd0);
        check_val("rst_rsp_retval", bus.rsp_retval, 64'd0);
        check_val("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Non-blocking call: issue two cycles after the push, retval 0, OK
        push(8'd3, 8'h11, 64'hA5, 1'b0, 64'd0, 2'd0);
        check_val("nb_lat_n1", 64'(bus.bfm_valid), 64'd0);
        @(negedge clock);
        check_val("nb_lat_n2", 64'(bus.bfm_valid), 64'd1);
        drain();

        // Blocking call answered five cycles after issue
        push(8'd5, 8'h22, 64'h1234, 1'b1, 64'hDEAD, 2'd0);
        wait_issue();
        repeat (5) @(negedge clock);
        pulse_rsp(64'hDEAD);
        drain();

        // Timeout: response 16 edges after the issue handshake edge
        push(8'd7, 8'h33, 64'h0, 1'b1, 64'd0, 2'd1);
        wait_issue();
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.rsp_valid && n < 100);
        check_val("timeout_latency", 64'(n - 1), 64'd16);
        drain();

        // Response in the same cycle as the timeout wins
        push(8'd8, 8'h44, 64'h99, 1'b1, 64'hBEEF, 2'd0);
        wait_issue();
        repeat (16) @(negedge clock);
        pulse_rsp(64'hBEEF);
        drain();

        // Back-pressure: one call stuck in ISSUE plus a full FIFO
        bus.bfm_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(8'(i + 1), 8'(8'h50 + i), 64'(64'h100 + i), 1'b0, 64'd0, 2'd0);
        end
        repeat (2) @(negedge clock);
        check_val("bp_count", 64'(count), 64'd4);
        check_val("bp_req_ready", 64'(bus.req_ready), 64'd0);
        check_val("bp_busy", 64'(busy), 64'd1);
        bus.req_call_id = 8'h5F;
        bus.req_valid   = 1'b1;
        repeat (3) @(negedge clock);
        bus.req_valid   = 1'b0;
        check_val("bp_extra_rejected", 64'(count), 64'd4);
        bus.bfm_ready = 1'b1;
        drain();
        check_val("bp_count_empty", 64'(count), 64'd0);

        // Stray BFM response while idle
        check_val("idle_busy", 64'(busy), 64'd0);
        bus.bfm_rsp_valid = 1'b1;
        @(negedge clock);
        bus.bfm_rsp_valid = 1'b0;
        check_val("stray_flag", 64'(err_stray), 64'd1);
        repeat (3) @(negedge clock);
        check_val("stray_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check_val("stray_sticky", 64'(err_stray), 64'd1);

        // Reset while waiting for a BFM response discards the call
        push(8'd9, 8'h66, 64'h77, 1'b1, 64'd0, 2'd0);
        wait_issue();
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_bfm_valid", 64'(bus.bfm_valid), 64'd0);
        check_val("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("mid_rst_count", 64'(count), 64'd0);
        check_val("mid_rst_err_stray", 64'(err_stray), 64'd0);
        check_val("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        rsp_q.delete();
        issue_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.bfm_valid) seen = 1'b1;
        end
        check_val("no_activity_after_reset", 64'(seen), 64'd0);
        check_val("end_issue_q_empty", 64'(issue_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
